lsu_sequencer: RTL and testbench

//  Multi-cycle load/store sequencer between the execute stage and the data-memory bus.
//  - Accepts one memory op: direction, mem_acc_mode code, address, store data.
//  - Drives a req/gnt/rvalid bus handshake and stalls the pipeline until the op completes.
//  - Returns aligned, sign- or zero-extended load data to writeback; reports access and timeout errors.

---
 rtl/lsu_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
// Load/store sequencer between execute and the data bus.
// One op in flight; req/gnt/rvalid handshake with timeout.
module lsu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        access_err,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] M_B    = 3'b000;
  localparam logic [2:0] M_H    = 3'b001;
  localparam logic [2:0] M_W    = 3'b010;
  localparam logic [2:0] M_BU   = 3'b011;
  localparam logic [2:0] M_HU   = 3'b100;
  localparam logic [2:0] M_NONE = 3'b111;

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  state_t state_q;
  state_t state_d;

  logic          we_q;
  logic [2:0]    mode_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic          to_q;
  logic [31:0]   rdata_q;

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        op_go;
  logic        illegal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        to_last;
  logic        busy;
  logic        load_done;
  logic        to_abort;
  logic [31:0] lane;
  logic [31:0] ext;

  // Width class of the incoming op; unsigned modes share a lane width.
  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    unique case (req_mode)
      M_B, M_BU: is_b = 1'b1;
      M_H, M_HU: is_h = 1'b1;
      M_W:       is_w = 1'b1;
      default:   ;
    endcase
  end

  assign op_go = req_valid && (req_mode != M_NONE);

  assign illegal = !(is_b || is_h || is_w)
                || (is_h && req_addr[0])
                || (is_w && (req_addr[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    unique case (1'b1)
      is_b: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      is_h: begin
        be_d    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_d = {2{req_wdata[15:0]}};
      end
      is_w: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
      default: ;
    endcase
  end

  assign to_last = (TIMEOUT_CYCLES != 0)
                && (cnt_q == CNT_LAST);

  assign busy = (state_q == S_REQ)
             || (state_q == S_WAIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_go) begin
          state_d = illegal ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt && (we_q || bus_rvalid)) begin
          state_d = S_DONE;
        end else if (to_last) begin
          state_d = S_ERR;
        end else if (bus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          state_d = S_DONE;
        end else if (to_last) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_done =
      ((state_q == S_REQ) && bus_gnt
        && !we_q && bus_rvalid)
    || ((state_q == S_WAIT) && bus_rvalid);

  assign to_abort = busy && (state_d == S_ERR);

  // Lane select, then extension according to the latched mode.
  assign lane = bus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ext = lane;
    unique case (mode_q)
      M_B:     ext = {{24{lane[7]}}, lane[7:0]};
      M_BU:    ext = {24'h0, lane[7:0]};
      M_H:     ext = {{16{lane[15]}}, lane[15:0]};
      M_HU:    ext = {16'h0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      mode_q  <= 3'b000;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else if ((state_q == S_IDLE) && op_go) begin
      we_q    <= req_we;
      mode_q  <= req_mode;
      addr_q  <= req_addr;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= 1'b0;
    end else if (to_abort) begin
      to_q <= 1'b1;
    end else if (state_q == S_IDLE) begin
      to_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else if (load_done) begin
      rdata_q <= ext;
    end else if (to_abort) begin
      rdata_q <= 32'h0;
    end
  end

  assign stall = rst_n
              && (((state_q == S_IDLE) && op_go) || busy);

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'h0;
    bus_be    = 4'b0000;
    bus_wdata = 32'h0;
    if (state_q == S_REQ) begin
      bus_req   = 1'b1;
      bus_we    = we_q;
      bus_addr  = {addr_q[31:2], 2'b00};
      bus_be    = be_q;
      bus_wdata = wdata_q;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = (state_q == S_DONE) && !we_q;
  assign access_err  = (state_q == S_ERR) && !to_q;
  assign timeout_err = (state_q == S_ERR) && to_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer.
// Timeout shortened to 8 cycles.
module tb_lsu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        access_err;
  logic        timeout_err;

  int n_chk;
  int n_fail;

  lsu_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_mode    (req_mode),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .access_err  (access_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end expected end of test");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic we,
                        input logic [2:0] m,
                        input logic [31:0] a,
                        input logic [31:0] wd);
    req_valid = v;
    req_we    = we;
    req_mode  = m;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic do_err(input string tag,
                        input logic [2:0] m,
                        input logic [31:0] a);
    set_op(1'b1, 1'b0, m, a, 32'h0);
    #1;
    chk({tag, "_stall"}, stall, 1);
    chk({tag, "_req0"}, bus_req, 0);
    step;
    req_valid = 1'b0;
    #1;
    chk({tag, "_aerr"}, access_err, 1);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_req1"}, bus_req, 0);
    chk({tag, "_stall1"}, stall, 0);
    step;
    chk({tag, "_aerr_end"}, access_err, 0);
  endtask

  // rvalid arrives n cycles after gnt (n=0: with gnt).
  task automatic load_wait(input string tag,
                           input logic [2:0] m,
                           input logic [31:0] a,
                           input int n,
                           input logic [31:0] d,
                           input logic [31:0] exp);
    set_op(1'b1, 1'b0, m, a, 32'h0);
    #1;
    chk({tag, "_stall0"}, stall, 1);
    step;
    bus_gnt    = 1'b1;
    bus_rvalid = (n == 0);
    bus_rdata  = d;
    #1;
    chk({tag, "_req"}, bus_req, 1);
    step;
    bus_gnt = 1'b0;
    if (n > 0) begin
      bus_rvalid = 1'b0;
      for (int i = 1; i < n; i++) begin
        #1;
        chk({tag, "_wait"}, stall, 1);
        step;
      end
      bus_rvalid = 1'b1;
      #1;
      chk({tag, "_wait_last"}, stall, 1);
      step;
    end
    bus_rvalid = 1'b0;
    req_valid  = 1'b0;
    #1;
    chk({tag, "_rv"}, rdata_valid, 1);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_stall"}, stall, 0);
    step;
    chk({tag, "_rv_end"}, rdata_valid, 0);
    chk({tag, "_hold"}, rdata, exp);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    set_op(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rv", rdata_valid, 0);
    chk("rst_err", {access_err, timeout_err}, 0);
    rst_n = 1'b1;
    step;

    // mode none never stalls
    set_op(1'b1, 1'b0, 3'b111, 32'h40, 32'h0);
    #1;
    chk("none_stall", stall, 0);
    step;
    chk("none_req", bus_req, 0);
    req_valid = 1'b0;

    // 1: LB 0x103
    set_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    #1;
    chk("lb_stall0", stall, 1);
    step;
    bus_gnt    = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h80FF_FF00;
    #1;
    chk("lb_req", bus_req, 1);
    chk("lb_we", bus_we, 0);
    chk("lb_addr", bus_addr, 32'h100);
    chk("lb_be", bus_be, 4'b1000);
    chk("lb_stall1", stall, 1);
    step;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    #1;
    chk("lb_rv", rdata_valid, 1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_stall2", stall, 0);
    chk("lb_req_done", bus_req, 0);
    req_valid = 1'b0;
    step;
    chk("lb_rv_end", rdata_valid, 0);

    // 2: SH 0x22, gnt after 3 cycles
    set_op(1'b1, 1'b1, 3'b001, 32'h22, 32'h1234_ABCD);
    #1;
    chk("sh_stall0", stall, 1);
    step;
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", bus_req, 1);
      chk("sh_we", bus_we, 1);
      chk("sh_addr", bus_addr, 32'h20);
      chk("sh_be", bus_be, 4'b1100);
      chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
      step;
    end
    bus_gnt = 1'b1;
    #1;
    chk("sh_gnt_wdata", bus_wdata, 32'hABCD_ABCD);
    step;
    bus_gnt = 1'b0;
    #1;
    chk("sh_rv", rdata_valid, 0);
    chk("sh_stall", stall, 0);
    chk("sh_req_done", bus_req, 0);
    chk("sh_wdata_done", bus_wdata, 0);
    req_valid = 1'b0;
    step;

    // SB with BU mode acts as SB
    set_op(1'b1, 1'b1, 3'b011, 32'h31, 32'h0000_005A);
    step;
    chk("sbu_be", bus_be, 4'b0010);
    chk("sbu_wdata", bus_wdata, 32'h5A5A_5A5A);
    bus_gnt = 1'b1;
    step;
    bus_gnt   = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("sbu_aerr", access_err, 0);
    step;

    // 3: illegal ops
    do_err("lw41", 3'b010, 32'h41);
    do_err("lhu43", 3'b100, 32'h43);
    do_err("m110", 3'b110, 32'h0);

    // 4: LHU/LH with 5-cycle read latency
    load_wait("lhu", 3'b100, 32'h2, 5,
              32'hF00F_0000, 32'h0000_F00F);
    load_wait("lh", 3'b001, 32'h2, 5,
              32'hF00F_0000, 32'hFFFF_F00F);
    load_wait("lbu", 3'b011, 32'h1, 0,
              32'h0000_9100, 32'h0000_0091);

    // 5: timeout, then rvalid in the final cycle
    set_op(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
    step;
    for (int i = 0; i < 8; i++) begin
      chk("to_req", bus_req, 1);
      chk("to_terr_early", timeout_err, 0);
      step;
    end
    req_valid = 1'b0;
    #1;
    chk("to_terr", timeout_err, 1);
    chk("to_aerr", access_err, 0);
    chk("to_stall", stall, 0);
    chk("to_req_end", bus_req, 0);
    chk("to_rdata", rdata, 0);
    step;
    chk("to_terr_end", timeout_err, 0);
    load_wait("to_last", 3'b010, 32'h84, 7,
              32'hCAFE_F00D, 32'hCAFE_F00D);

    // 6: reset during WAIT
    set_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    step;
    bus_gnt = 1'b1;
    step;
    bus_gnt = 1'b0;
    step;
    chk("rw_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_stall", stall, 0);
    chk("rw_req", bus_req, 0);
    chk("rw_rdata", rdata, 0);
    req_valid = 1'b0;
    step;
    rst_n      = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("rw_late_stall", stall, 0);
    step;
    bus_rvalid = 1'b0;
    chk("rw_late_rv", rdata_valid, 0);
    chk("rw_late_rdata", rdata, 0);
    load_wait("rw_lw", 3'b010, 32'h10, 0,
              32'h1357_9BDF, 32'h1357_9BDF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
